// File: rtl/regfile_pkg.sv
// Shared types and default parameter values for the multi-read-port register file.
package regfile_pkg;

    // Controller state: INIT fills the array with index values, RUN serves reads/writes.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    // Default geometry of the datapath register file.
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_READ = 2;
    localparam int RF_ZERO_REG = 31;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register check, same-cycle write bypass,
// array mux and output register. hold_zero forces the output to 0 while the
// file is still initialising.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_zero,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] data_nxt_s;
    logic [DATA_W-1:0] data_r;

    // Select the value this port will present after the next edge.
    always_comb begin
        data_nxt_s = '0;
        if (hold_zero) begin
            data_nxt_s = '0;
        end else if (rd_addr == ZERO_ADDR) begin
            // Zero register wins over the bypass, so a discarded write never leaks out.
            data_nxt_s = '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            data_nxt_s = wr_data;
        end else begin
            data_nxt_s = mem[rd_addr];
        end
    end

    // Output register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
        end else begin
            data_r <= data_nxt_s;
        end
    end

    assign rd_data = data_r;

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_READ registered read ports, one write
// port and same-cycle write-to-read bypass. After reset the array is filled
// with each register's own index (zero register gets 0) before ready rises.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = RF_NUM_READ,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       ready,
    output logic                       wr_drop
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    rf_state_t         state_r;
    rf_state_t         state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              ready_r;
    logic              ready_nxt_s;
    logic              drop_r;
    logic              drop_nxt_s;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // State, init counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= INIT;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
            drop_r  <= drop_nxt_s;
        end
    end

    // Next state: leave INIT after the last array location has been written.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            INIT: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // Per-state outputs: init fill or external write, status flags, counter step.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        ready_nxt_s = 1'b0;
        drop_nxt_s  = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_r;
        mem_wdata_s = '0;
        case (state_r)
            INIT: begin
                cnt_nxt_s   = cnt_r + ONE_ADDR;
                ready_nxt_s = (cnt_r == LAST_ADDR);
                // Any write attempt while initialising is dropped and flagged.
                drop_nxt_s  = wr_en;
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r;
                if (cnt_r == ZERO_ADDR) begin
                    mem_wdata_s = '0;
                end else begin
                    mem_wdata_s = DATA_W'(cnt_r);
                end
            end
            RUN: begin
                cnt_nxt_s   = cnt_r;
                ready_nxt_s = 1'b1;
                drop_nxt_s  = 1'b0;
                if (wr_en && (wr_addr != ZERO_ADDR)) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_addr;
                    mem_wdata_s = wr_data;
                end else begin
                    // Writes to the zero register are silently discarded.
                    mem_we_s    = 1'b0;
                    mem_waddr_s = wr_addr;
                    mem_wdata_s = '0;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                ready_nxt_s = 1'b0;
                drop_nxt_s  = 1'b0;
                mem_we_s    = 1'b0;
            end
        endcase
    end

    // Storage array; contents are rebuilt by the init sequence, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // One independent read port per requested reader.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .hold_zero (!ready_r),
            .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .mem       (mem_r),
            .rd_data   (rd_data[p*DATA_W +: DATA_W])
        );
    end

    assign ready   = ready_r;
    assign wr_drop = drop_r;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance (32x32, 2 ports, zero
// reg 31) and a swept instance (16x64, 3 ports, zero reg 0) side by side.
module tb_regfile_mp;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    // Instance A: defaults
    logic [9:0]   rd_addr_a = '0;
    logic [63:0]  rd_data_a;
    logic         wr_en_a   = 1'b0;
    logic [4:0]   wr_addr_a = '0;
    logic [31:0]  wr_data_a = '0;
    logic         ready_a;
    logic         drop_a;

    // Instance B: DATA_W=64, ADDR_W=4, NUM_READ=3, ZERO_REG=0
    logic [11:0]  rd_addr_b = '0;
    logic [191:0] rd_data_b;
    logic         wr_en_b   = 1'b0;
    logic [3:0]   wr_addr_b = '0;
    logic [63:0]  wr_data_b = '0;
    logic         ready_b;
    logic         drop_b;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [31:0] mem_a [32];
    logic [63:0] mem_b [16];

    always #5 clk = ~clk;

    regfile_mp u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr_a),
        .rd_data (rd_data_a),
        .wr_en   (wr_en_a),
        .wr_addr (wr_addr_a),
        .wr_data (wr_data_a),
        .ready   (ready_a),
        .wr_drop (drop_a)
    );

    regfile_mp #(
        .DATA_W   (64),
        .ADDR_W   (4),
        .NUM_READ (3),
        .ZERO_REG (0)
    ) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr_b),
        .rd_data (rd_data_b),
        .wr_en   (wr_en_b),
        .wr_addr (wr_addr_b),
        .wr_data (wr_data_b),
        .ready   (ready_b),
        .wr_drop (drop_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural contents after a completed initialisation.
    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_a[i] = (i == 31) ? 32'd0 : 32'(i);
        for (int i = 0; i < 16; i++) mem_b[i] = (i == 0) ? 64'd0 : 64'(i);
        edges = 0;
    endtask

    // Predict both instances for one clock edge, advance, then compare.
    task automatic cyc();
        logic [31:0] ea [2];
        logic [63:0] eb [3];
        logic        da;
        logic        db;
        logic [4:0]  a;
        logic [3:0]  b;
        if (edges >= 32) begin
            for (int p = 0; p < 2; p++) begin
                a = rd_addr_a[p*5 +: 5];
                if (a == 5'd31) ea[p] = 32'd0;
                else if (wr_en_a && wr_addr_a == a) ea[p] = wr_data_a;
                else ea[p] = mem_a[a];
            end
            da = 1'b0;
            if (wr_en_a && wr_addr_a != 5'd31) mem_a[wr_addr_a] = wr_data_a;
        end else begin
            ea[0] = 32'd0;
            ea[1] = 32'd0;
            da    = wr_en_a;
        end
        if (edges >= 16) begin
            for (int p = 0; p < 3; p++) begin
                b = rd_addr_b[p*4 +: 4];
                if (b == 4'd0) eb[p] = 64'd0;
                else if (wr_en_b && wr_addr_b == b) eb[p] = wr_data_b;
                else eb[p] = mem_b[b];
            end
            db = 1'b0;
            if (wr_en_b && wr_addr_b != 4'd0) mem_b[wr_addr_b] = wr_data_b;
        end else begin
            for (int p = 0; p < 3; p++) eb[p] = 64'd0;
            db = wr_en_b;
        end
        edges++;
        @(posedge clk);
        #1;
        chk("A.rd0",   64'(rd_data_a[31:0]),  64'(ea[0]));
        chk("A.rd1",   64'(rd_data_a[63:32]), 64'(ea[1]));
        chk("A.ready", 64'(ready_a),          64'(edges >= 32));
        chk("A.drop",  64'(drop_a),           64'(da));
        chk("B.rd0",   rd_data_b[63:0],       eb[0]);
        chk("B.rd1",   rd_data_b[127:64],     eb[1]);
        chk("B.rd2",   rd_data_b[191:128],    eb[2]);
        chk("B.ready", 64'(ready_b),          64'(edges >= 16));
        chk("B.drop",  64'(drop_b),           64'(db));
    endtask

    task automatic rand_inputs(input bit allow_wr);
        wr_en_a   = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
        wr_addr_a = 5'($urandom_range(0, 31));
        wr_data_a = $urandom;
        for (int p = 0; p < 2; p++)
            rd_addr_a[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr_a : 5'($urandom_range(0, 31));
        wr_en_b   = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
        wr_addr_b = 4'($urandom_range(0, 15));
        wr_data_b = {$urandom, $urandom};
        for (int p = 0; p < 3; p++)
            rd_addr_b[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? wr_addr_b : 4'($urandom_range(0, 15));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".rd_a"},  rd_data_a,          64'd0);
        chk({tag, ".rdy_a"}, 64'(ready_a),       64'd0);
        chk({tag, ".drp_a"}, 64'(drop_a),        64'd0);
        chk({tag, ".rd_b"},  64'(|rd_data_b),    64'd0);
        chk({tag, ".rdy_b"}, 64'(ready_b),       64'd0);
        chk({tag, ".drp_b"}, 64'(drop_b),        64'd0);
    endtask

    initial begin
        // Reset for one clock edge.
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all_zero("reset");

        // Initialisation, with a write attempt before edge 5.
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                wr_en_a = 1'b1; wr_addr_a = 5'd12; wr_data_a = 32'd99;
            end else begin
                wr_en_a = 1'b0;
            end
            cyc();
            if (i == 5) chk("init.drop_hi", 64'(drop_a), 64'd1);
            if (i == 6) chk("init.drop_lo", 64'(drop_a), 64'd0);
            if (i == 31) chk("init.ready31", 64'(ready_a), 64'd0);
        end
        chk("init.ready32", 64'(ready_a), 64'd1);

        // Reads of 0, 4 and the zero register.
        rd_addr_a = {5'd4, 5'd0};
        cyc();
        chk("run.rd0", 64'(rd_data_a[31:0]), 64'd0);
        chk("run.rd4", 64'(rd_data_a[63:32]), 64'd4);
        rd_addr_a = {5'd4, 5'd31};
        cyc();
        chk("run.rd31", 64'(rd_data_a[31:0]), 64'd0);

        // Write with same-cycle bypass, then both ports from the array.
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'd15; rd_addr_a = {5'd4, 5'd3};
        cyc();
        chk("bypass.rd0", 64'(rd_data_a[31:0]), 64'd15);
        wr_en_a = 1'b0; rd_addr_a = {5'd3, 5'd3};
        cyc();
        chk("array.rd0", 64'(rd_data_a[31:0]), 64'd15);
        chk("array.rd1", 64'(rd_data_a[63:32]), 64'd15);

        // Back-to-back writes to one address: last one wins.
        wr_en_a = 1'b1; wr_addr_a = 5'd6; wr_data_a = 32'h1111_1111; rd_addr_a = {5'd6, 5'd6};
        cyc();
        wr_data_a = 32'h2222_2222;
        cyc();
        chk("b2b.bypass", 64'(rd_data_a[31:0]), 64'h2222_2222);
        wr_en_a = 1'b0;
        cyc();
        chk("b2b.array", 64'(rd_data_a[63:32]), 64'h2222_2222);

        // Write to the zero register is discarded without a drop pulse.
        wr_en_a = 1'b1; wr_addr_a = 5'd31; wr_data_a = 32'hDEAD_BEEF; rd_addr_a = {5'd31, 5'd31};
        cyc();
        chk("zero.bypass", 64'(rd_data_a[31:0]), 64'd0);
        chk("zero.drop", 64'(drop_a), 64'd0);
        wr_en_a = 1'b0;
        cyc();
        chk("zero.array", 64'(rd_data_a[63:32]), 64'd0);

        // Dropped init write left the index value in reg 12.
        rd_addr_a = {5'd0, 5'd12};
        cyc();
        chk("drop.rd12", 64'(rd_data_a[31:0]), 64'd12);

        // Swept instance: duplicate reads and a wide write.
        rd_addr_b = {4'd0, 4'd5, 4'd5};
        cyc();
        chk("B.rd5a", rd_data_b[63:0], 64'd5);
        chk("B.rd5b", rd_data_b[127:64], 64'd5);
        chk("B.rd0", rd_data_b[191:128], 64'd0);
        wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 64'h0000_0100_0000_0000; rd_addr_b = {4'd0, 4'd0, 4'd9};
        cyc();
        chk("B.bypass9", rd_data_b[63:0], 64'h0000_0100_0000_0000);
        wr_en_b = 1'b0; rd_addr_b = {4'd9, 4'd0, 4'd0};
        cyc();
        chk("B.array9", rd_data_b[191:128], 64'h0000_0100_0000_0000);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b1);
            cyc();
        end

        // Mid-run write then asynchronous reset.
        wr_en_a = 1'b1; wr_addr_a = 5'd8; wr_data_a = 32'd7; rd_addr_a = {5'd8, 5'd8};
        wr_en_b = 1'b0;
        cyc();
        wr_en_a = 1'b0;
        cyc();
        chk("pre_reset.rd8", 64'(rd_data_a[31:0]), 64'd7);
        reset = 1'b1;
        #2;
        check_all_zero("async_reset");
        reset = 1'b0;
        model_reset();

        // Re-initialisation with random write attempts, then reg 8 reads its index.
        for (int i = 1; i <= 32; i++) begin
            rand_inputs(1'b1);
            if (i > 16) wr_en_b = 1'b0;
            cyc();
        end
        wr_en_a = 1'b0; wr_en_b = 1'b0; rd_addr_a = {5'd8, 5'd8};
        cyc();
        chk("reinit.rd8", 64'(rd_data_a[31:0]), 64'd8);

        for (int i = 0; i < 200; i++) begin
            rand_inputs(1'b1);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the datapath, successor to the fixed 32×32 two-read-port file. After reset it runs an initialisation sequence that loads every register with its own index and the zero register with 0, then signals `ready`. During normal operation it serves `NUM_READ` registered read ports and one write port, with same-cycle write-to-read bypass. It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth `DEPTH = 2**ADDR_W`.
- `NUM_READ`, default 2: number of read ports, ≥1.
- `ZERO_REG`, default 31: index hardwired to 0; writes to it are discarded.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rd_addr`  in  NUM_READ*ADDR_W: read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_READ*DATA_W: registered read data; port p uses bits [p*DATA_W +: DATA_W].
- `wr_en`  in  1: write enable.
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W: write data.
- `ready`  out  1: high once initialisation is complete.
- `wr_drop`  out  1: one-cycle registered pulse when `wr_en` is asserted while not ready.

## Operation
- State machine with states INIT and RUN. Reset forces INIT with init counter `cnt` = 0.
- INIT: each edge writes `mem[cnt] = cnt`, zero-extended to DATA_W. `mem[ZERO_REG]` is written 0 instead. Then `cnt` increments.
  - When `cnt == DEPTH-1`, the last write occurs and the state moves to RUN.
  - External writes are ignored. `wr_drop` is set to `wr_en`.
  - `rd_data` is held at 0.
- RUN: on each edge, if `wr_en` and `wr_addr != ZERO_REG`, then `mem[wr_addr] <= wr_data`.
  - Each read port p registers `rd_data[p] <= value(rd_addr[p])`, where `value(a)` is:
    - 0 if `a == ZERO_REG`;
    - else `wr_data` if `wr_en` and `wr_addr == a` (bypass);
    - else `mem[a]`.
  - `wr_drop` is 0.
- Read ports are independent. Several ports may read the same address in the same cycle, and all return the same value.
- Write to `ZERO_REG` in RUN is silently discarded. It does not raise `wr_drop`, and no bypass applies.
- Reset asserted mid-operation clears everything immediately:
  - `rd_data = 0`, `ready = 0`, `wr_drop = 0`, state INIT, `cnt = 0`.
  - Contents are re-initialised over the following DEPTH cycles; the array itself is not reset asynchronously.
- No debug printing in RTL.

## Timing
- Reset values: `rd_data` all 0, `ready` 0, `wr_drop` 0, state INIT, `cnt` 0.
- Initialisation takes exactly DEPTH rising edges after reset deasserts. `ready` is registered and rises on edge DEPTH (edge 32 for the defaults).
- Read latency is 1 cycle. An address presented before edge N yields data valid after edge N.
- Write latency:
  - Data written at edge N is visible through a read sampled at edge N via the bypass.
  - From edge N+1 onward it is visible from the array.
- Write and read to the same address in one cycle return the new data.
- Back-to-back writes to the same address: the last write wins. A read at the same edge as the second write returns the second value.
- `wr_drop` is asserted the cycle after an ignored write attempt, for one cycle per attempt.

## Structure
- Package `regfile_pkg`:
  - state enum `rf_state_t` {INIT, RUN};
  - default parameter constants `RF_DATA_W`, `RF_ADDR_W`, `RF_NUM_READ`, `RF_ZERO_REG`.
- Sub-module `regfile_read_port`, instantiated NUM_READ times via generate. It contains the zero-check, bypass compare, array mux and output register, plus a `hold_zero` input driven by `!ready`.
- The top level holds the storage array, init counter, state machine, write logic and `wr_drop`.

## Test plan
- Reset 1 cycle, then wait:
  - `ready` is low for edges 1–31 and high after edge 32.
  - In RUN, read 0, 4, 31 → `rd_data` 0, 4, 0.
- Write 15 to reg 3 with `rd_addr[0]` = 3 in the same cycle:
  - → `rd_data[0]` = 15 next cycle (bypass).
  - Next cycle, read 3 on both ports → both 15.
- Write 0xDEADBEEF to reg 31, then read 31 → 0. `wr_drop` stays 0.
- Assert `wr_en` (addr 12, data 99) during INIT cycle 5:
  - → `wr_drop` = 1 for one cycle.
  - After ready, read 12 → 12.
- Mid-run, write 7 to reg 8, then pulse `reset`:
  - → outputs 0 immediately, `ready` low for 32 edges.
  - Afterwards read 8 → 8.
- Parameter sweep `DATA_W`=64, `ADDR_W`=4, `NUM_READ`=3, `ZERO_REG`=0:
  - `ready` after 16 edges.
  - Three simultaneous reads of 5, 5, 0 → 5, 5, 0.
  - A write of 2^40 to reg 9 reads back as 2^40.
